// File: rtl/fetch_loader_ctrl.sv
// Instruction-fetch sequencer: assembles big-endian words from a host byte stream,
// writes them to instruction memory, then runs or single-steps the program until HALT.
module fetch_loader_ctrl #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int PC_LENGTH          = 32,
    parameter int MEM_DEPTH          = 256,
    parameter logic [INSTRUCTION_LENGTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] instruction,
    output logic                          mips_enable,
    output logic                          pc_enable,
    output logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
    output logic [PC_LENGTH-1:0]          address_to_write,
    output logic [15:0]                   loaded_words,
    output logic                          overflow,
    output logic                          halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_RUN    = 3'd3,
        S_STEP   = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_WORDS = 16'(MEM_DEPTH);

    state_t                          state_q, state_d;
    logic [1:0]                      byte_cnt_q, byte_cnt_d;
    logic [INSTRUCTION_LENGTH-1:0]   word_q, word_d;
    logic [15:0]                     word_idx_q, word_idx_d;
    logic                            overflow_q, overflow_d;
    logic [INSTRUCTION_LENGTH-1:0]   itw_q, itw_d;
    logic [PC_LENGTH-1:0]            atw_q, atw_d;
    logic                            mips_enable_q, mips_enable_d;
    logic                            rx_ready_q, rx_ready_d;
    logic                            halted_q, halted_d;
    logic                            accept_s;
    logic                            halt_seen_s;

    assign accept_s    = rx_valid & rx_ready_q;
    assign halt_seen_s = (instruction == HALT_WORD);

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        overflow_d = overflow_q;
        itw_d      = itw_q;
        atw_d      = atw_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (rx_data)
                        8'h01: begin
                            state_d    = S_LOAD;
                            word_idx_d = 16'd0;
                            byte_cnt_d = 2'd0;
                            overflow_d = 1'b0;
                        end
                        8'h02:   state_d = S_RUN;
                        8'h03:   state_d = S_STEP;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    word_d = {word_q[INSTRUCTION_LENGTH-9:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        // A full memory drops the word entirely instead of wrapping the address
                        if (word_idx_q == DEPTH_WORDS) begin
                            overflow_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            itw_d   = {word_q[INSTRUCTION_LENGTH-9:0], rx_data};
                            atw_d   = PC_LENGTH'({word_idx_q, 2'b00});
                            state_d = S_WRITE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if (itw_q == HALT_WORD) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (halt_seen_s) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (halt_seen_s) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        mips_enable_d = (state_d != S_WRITE);
        rx_ready_d    = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_HALTED);
        halted_d      = (state_d == S_HALTED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= 2'd0;
            word_q        <= '0;
            word_idx_q    <= 16'd0;
            overflow_q    <= 1'b0;
            itw_q         <= '0;
            atw_q         <= '0;
            mips_enable_q <= 1'b1;
            rx_ready_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            word_idx_q    <= word_idx_d;
            overflow_q    <= overflow_d;
            itw_q         <= itw_d;
            atw_q         <= atw_d;
            mips_enable_q <= mips_enable_d;
            rx_ready_q    <= rx_ready_d;
            halted_q      <= halted_d;
        end
    end

    // PC advance follows the fetched instruction within the same cycle
    always_comb begin
        if (reset) begin
            pc_enable = 1'b0;
        end else if ((state_q == S_RUN) || (state_q == S_STEP)) begin
            pc_enable = !halt_seen_s;
        end else begin
            pc_enable = 1'b0;
        end
    end

    assign rx_ready             = rx_ready_q;
    assign mips_enable          = mips_enable_q;
    assign instruction_to_write = itw_q;
    assign address_to_write     = atw_q;
    assign loaded_words         = word_idx_q;
    assign overflow             = overflow_q;
    assign halted               = halted_q;

endmodule
